// File: rtl/core_task_receiver_pkg.sv
// Shared definitions for the per-core task receiver.
// Defaults match the task scheduler's bus geometry.
package core_task_receiver_pkg;

  localparam int unsigned CORES_COUNT_DEF = 16;
  localparam int unsigned INSN_COUNT_DEF  = 16;
  localparam int unsigned INSN_SIZE_DEF   = 16;
  localparam int unsigned REG_SIZE_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } task_state_t;

endpackage

// File: rtl/core_task_receiver_insn_buffer.sv
// Task instruction store: whole frame written in one cycle, single registered read port.
// The storage array is intentionally not reset; only the read register is.
module core_task_receiver_insn_buffer
  import core_task_receiver_pkg::*;
#(
  parameter int unsigned INSN_COUNT = INSN_COUNT_DEF,
  parameter int unsigned INSN_SIZE  = INSN_SIZE_DEF,
  parameter int unsigned PC_W       = $clog2(INSN_COUNT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_wr_en,
  input  logic [INSN_COUNT*INSN_SIZE-1:0] i_frame,
  input  logic                            i_rd_en,
  input  logic [PC_W-1:0]                 i_rd_addr,
  output logic [INSN_SIZE-1:0]            o_rd_data
);

  logic [INSN_SIZE-1:0] r_mem [INSN_COUNT];
  logic [INSN_SIZE-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < int'(INSN_COUNT); k++) begin
        r_mem[k] <= i_frame[k*INSN_SIZE +: INSN_SIZE];
      end
    end
  end

  // Read data holds its last value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/core_task_receiver.sv
// Per-core task receiver: accepts a broadcast task frame, latches R0 init,
// serves 1-cycle instruction fetches while running and pulses task_done on halt.
module core_task_receiver
  import core_task_receiver_pkg::*;
#(
  parameter int unsigned CORES_COUNT = CORES_COUNT_DEF,
  parameter int unsigned CORE_ID     = 0,
  parameter int unsigned INSN_COUNT  = INSN_COUNT_DEF,
  parameter int unsigned INSN_SIZE   = INSN_SIZE_DEF,
  parameter int unsigned REG_SIZE    = REG_SIZE_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CORES_COUNT-1:0]            i_start,
  input  logic [INSN_COUNT*INSN_SIZE-1:0]   i_insn_data,
  input  logic [CORES_COUNT-1:0]            i_init_r0_vect,
  input  logic [CORES_COUNT*REG_SIZE-1:0]   i_init_r0,
  output logic                              o_ready,
  output logic                              o_r0_we,
  output logic [REG_SIZE-1:0]               o_r0_val,
  input  logic                              i_fetch_req,
  input  logic [$clog2(INSN_COUNT)-1:0]     i_fetch_pc,
  output logic [INSN_SIZE-1:0]              o_fetch_insn,
  output logic                              o_fetch_vld,
  input  logic                              i_core_halt,
  output logic                              o_task_done
);

  localparam int unsigned PC_W = $clog2(INSN_COUNT);

  task_state_t         r_state;
  logic                r_ready;
  logic                r_r0_we;
  logic [REG_SIZE-1:0] r_r0_val;
  logic                r_fetch_vld;
  logic                r_task_done;

  logic                w_start;
  logic                w_init_r0;
  logic [REG_SIZE-1:0] w_init_r0_val;
  logic                w_buf_we;
  logic                w_buf_re;
  logic                w_unused;

  // Only this core's bit/slice of the broadcast buses matters.
  assign w_start       = i_start[CORE_ID];
  assign w_init_r0     = i_init_r0_vect[CORE_ID];
  assign w_init_r0_val = i_init_r0[CORE_ID*REG_SIZE +: REG_SIZE];
  assign w_unused      = ^{i_start, i_init_r0_vect, i_init_r0};

  assign w_buf_we = (r_state == ST_LOAD) && !rst;
  assign w_buf_re = (r_state == ST_RUN) && i_fetch_req && !rst;

  core_task_receiver_insn_buffer #(
    .INSN_COUNT (INSN_COUNT),
    .INSN_SIZE  (INSN_SIZE),
    .PC_W       (PC_W)
  ) u_insn_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_buf_we),
    .i_frame   (i_insn_data),
    .i_rd_en   (w_buf_re),
    .i_rd_addr (i_fetch_pc),
    .o_rd_data (o_fetch_insn)
  );

  // Task FSM; pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_r0_we     <= 1'b0;
      r_r0_val    <= '0;
      r_fetch_vld <= 1'b0;
      r_task_done <= 1'b0;
    end else begin
      r_r0_we     <= 1'b0;
      r_fetch_vld <= 1'b0;
      r_task_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_LOAD;
            r_ready <= 1'b0;
            if (w_init_r0) begin
              r_r0_we  <= 1'b1;
              r_r0_val <= w_init_r0_val;
            end
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_fetch_vld <= i_fetch_req;
          if (i_core_halt) begin
            r_state     <= ST_DONE;
            r_task_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_r0_we     = r_r0_we;
  assign o_r0_val    = r_r0_val;
  assign o_fetch_vld = r_fetch_vld;
  assign o_task_done = r_task_done;

endmodule
